// File: rtl/fetch_pkg.sv
// Shared fetch-front types and helpers, used by the line requester and the instruction line queue.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int LINE_BYTES     = 16;
  localparam int INSTR_PER_LINE = 4;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~32'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_line_requester.sv
// Requests 128-bit instruction lines from memory and writes them into the line queue.
// A redirect turns the next delivered line into a queue flush that carries the target word offset.
module fetch_line_requester
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    LINE_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [LINE_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_fifo_full,
  output logic                  o_fifo_wen,
  output logic                  o_fifo_flush,
  output logic [LINE_WIDTH-1:0] o_fifo_wdata,
  output logic [1:0]            o_fifo_off,
  output logic                  o_redirect_pending
);

  fetch_state_e          state_reg;
  logic [ADDR_WIDTH-1:0] line_addr_reg;
  logic [1:0]            off_reg;
  logic                  flush_pending_reg;
  logic [LINE_WIDTH-1:0] hold_reg;
  logic                  write_slot;

  // A redirect in the write cycle kills the held line before it reaches the queue.
  assign write_slot = (state_reg == WRITE) && !i_rst && !i_redirect;

  assign o_mem_req          = (state_reg == REQ) && !i_rst;
  assign o_mem_addr         = line_addr_reg;
  assign o_fifo_flush       = write_slot && flush_pending_reg;
  assign o_fifo_wen         = write_slot && !flush_pending_reg && !i_fifo_full;
  assign o_fifo_wdata       = hold_reg;
  assign o_fifo_off         = o_fifo_flush ? off_reg : 2'b00;
  assign o_redirect_pending = flush_pending_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg         <= REQ;
      line_addr_reg     <= line_align(RESET_PC);
      off_reg           <= RESET_PC[3:2];
      flush_pending_reg <= 1'b1;
      hold_reg          <= '0;
    end else if (i_redirect) begin
      line_addr_reg     <= line_align(i_redirect_pc);
      off_reg           <= i_redirect_pc[3:2];
      flush_pending_reg <= 1'b1;
      // Any request already accepted by memory must have its response discarded.
      case (state_reg)
        REQ:         state_reg <= i_mem_ready ? DRAIN : REQ;
        WAIT, DRAIN: state_reg <= i_mem_rvalid ? REQ : DRAIN;
        WRITE:       state_reg <= REQ;
      endcase
    end else begin
      case (state_reg)
        REQ: begin
          if (i_mem_ready) state_reg <= WAIT;
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            hold_reg  <= i_mem_rdata;
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          // A flush always lands; a plain write waits for queue space with the line held.
          if (flush_pending_reg || !i_fifo_full) begin
            flush_pending_reg <= 1'b0;
            line_addr_reg     <= line_addr_reg + ADDR_WIDTH'(LINE_BYTES);
            state_reg         <= REQ;
          end
        end
        DRAIN: begin
          if (i_mem_rvalid) state_reg <= REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_line_requester.sv
// Directed and randomized checking of fetch_line_requester against a transaction-level model.
module tb_fetch_line_requester;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         redirect = 1'b0;
  logic [31:0]  redirect_pc = '0;
  logic         mem_ready = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [127:0] mem_rdata = '0;
  logic         fifo_full = 1'b0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         fifo_wen, fifo_flush, redirect_pending;
  logic [127:0] fifo_wdata;
  logic [1:0]   fifo_off;

  always #5 clk = ~clk;

  fetch_line_requester dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_redirect         (redirect),
    .i_redirect_pc      (redirect_pc),
    .o_mem_req          (mem_req),
    .o_mem_addr         (mem_addr),
    .i_mem_ready        (mem_ready),
    .i_mem_rvalid       (mem_rvalid),
    .i_mem_rdata        (mem_rdata),
    .i_fifo_full        (fifo_full),
    .o_fifo_wen         (fifo_wen),
    .o_fifo_flush       (fifo_flush),
    .o_fifo_wdata       (fifo_wdata),
    .o_fifo_off         (fifo_off),
    .o_redirect_pending (redirect_pending)
  );

  int total = 0;
  int bad   = 0;

  // memory slave: one outstanding request, response after a chosen delay
  logic        mem_busy = 1'b0;
  logic [31:0] mem_line_addr = '0;
  int          mem_cnt = 0;
  int          mem_delay_min = 1;
  int          mem_delay_max = 1;

  // transaction-level model of what fetch must deliver
  logic [31:0]  m_pc = '0;
  logic [1:0]   m_off = '0;
  logic         m_flush_due = 1'b1;
  logic         m_infl = 1'b0;
  logic         m_infl_live = 1'b0;
  logic [31:0]  m_infl_addr = '0;
  logic         m_held = 1'b0;
  logic [127:0] m_held_data = '0;

  logic         s_req, s_wen, s_flush, s_pend;
  logic [31:0]  s_addr;
  logic [127:0] s_wdata;
  logic [1:0]   s_off;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a, a + 32'h0000_1357, a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic rd, input logic [31:0] rpc,
                     input logic rdy, input logic fl);
    logic e_req, e_wen, e_flush, acc, resp;
    @(negedge clk);
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    mem_ready   = rdy;
    fifo_full   = fl;
    mem_rvalid  = mem_busy && (mem_cnt == 0);
    mem_rdata   = mem_rvalid ? line_of(mem_line_addr) : {$urandom, $urandom, $urandom, $urandom};
    #1;
    s_req = mem_req;   s_addr = mem_addr;   s_wen = fifo_wen;   s_flush = fifo_flush;
    s_wdata = fifo_wdata;   s_off = fifo_off;   s_pend = redirect_pending;

    e_req   = !r && !m_infl && !m_held;
    e_flush = !r && !rd && m_held && m_flush_due;
    e_wen   = !r && !rd && m_held && !m_flush_due && !fl;
    chk("mem_req", s_req, e_req);
    chk("fifo_flush", s_flush, e_flush);
    chk("fifo_wen", s_wen, e_wen);
    if (!r) chk("redirect_pending", s_pend, m_flush_due);
    if (e_req) chk("mem_addr", s_addr, m_pc);
    if (e_flush || e_wen) chk("fifo_wdata", s_wdata, m_held_data);
    if (e_flush) chk("fifo_off", s_off, m_off);
    $display("cyc t=%0t rst=%0b rd=%0b pc=%h rdy=%0b full=%0b rv=%0b | req=%0b addr=%h wen=%0b flush=%0b off=%0d pend=%0b",
             $time, r, rd, rpc, rdy, fl, mem_rvalid, s_req, s_addr, s_wen, s_flush, s_off, s_pend);

    @(posedge clk);
    if (r) begin
      mem_busy = 1'b0;
    end else begin
      if (mem_rvalid) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (s_req && rdy) begin
        mem_busy      = 1'b1;
        mem_line_addr = s_addr;
        mem_cnt       = int'($urandom_range(mem_delay_max, mem_delay_min)) - 1;
      end
    end

    acc  = e_req && rdy;
    resp = mem_rvalid && m_infl;
    if (r) begin
      m_pc = RST_PC & ~32'hF;  m_off = RST_PC[3:2];  m_flush_due = 1'b1;
      m_infl = 1'b0;  m_held = 1'b0;
    end else if (rd) begin
      m_pc = rpc & ~32'hF;  m_off = rpc[3:2];  m_flush_due = 1'b1;  m_held = 1'b0;
      if (acc) begin m_infl = 1'b1; m_infl_live = 1'b0; end
      else if (resp) m_infl = 1'b0;
      else m_infl_live = 1'b0;
    end else begin
      if (acc) begin m_infl = 1'b1; m_infl_live = 1'b1; m_infl_addr = m_pc; end
      if (resp) begin
        m_infl = 1'b0;
        if (m_infl_live) begin m_held = 1'b1; m_held_data = line_of(m_infl_addr); end
      end
      if (e_flush || e_wen) begin
        m_held = 1'b0;
        m_pc   = m_pc + 32'd16;
        if (e_flush) m_flush_due = 1'b0;
      end
    end
  endtask

  task automatic step(input logic rdy, input logic fl);
    cyc(1'b0, 1'b0, 32'h0, rdy, fl);
  endtask

  task automatic redir(input logic [31:0] pc, input logic rdy, input logic fl);
    cyc(1'b0, 1'b1, pc, rdy, fl);
  endtask

  initial begin
    logic [127:0] wd;
    logic [31:0]  rpc;
    // 1: reset, sequential fetch
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1, 0); chk("t1_req", s_req, 1); chk("t1_addr0", s_addr, 32'h0040_0000);
    step(1, 0);
    step(1, 0); chk("t1_flush", s_flush, 1); chk("t1_off", s_off, 0); chk("t1_pend", s_pend, 1);
                chk("t1_wdata", s_wdata, line_of(32'h0040_0000));
    step(1, 0); chk("t1_addr1", s_addr, 32'h0040_0010); chk("t1_pend_fall", s_pend, 0);
    step(1, 0);
    step(1, 0); chk("t1_wen", s_wen, 1);
    mem_delay_min = 3; mem_delay_max = 3;
    step(1, 0); chk("t1_addr2", s_addr, 32'h0040_0020);
    // 2: redirect while waiting
    redir(32'h0040_0128, 1, 0);
    step(1, 0);
    step(1, 0); chk("t2_nowrite", s_wen | s_flush, 0);
    mem_delay_min = 1; mem_delay_max = 1;
    step(1, 0); chk("t2_addr", s_addr, 32'h0040_0120);
    step(1, 0);
    step(1, 0); chk("t2_flush", s_flush, 1); chk("t2_off", s_off, 2);
    step(1, 0);
    step(1, 0);
    // 3: queue full while holding a line
    step(1, 1); wd = s_wdata; chk("t3_wen_low0", s_wen, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1);
      chk("t3_wen_low", s_wen, 0); chk("t3_wdata_stable", s_wdata, wd); chk("t3_noreq", s_req, 0);
    end
    step(1, 0); chk("t3_wen_pulse", s_wen, 1); chk("t3_wdata", s_wdata, line_of(32'h0040_0130));
    step(1, 0); chk("t3_addr_next", s_addr, 32'h0040_0140);
    // 4: redirect with rvalid, then redirect in write while full
    redir(32'h0040_0200, 1, 0);
    step(1, 0); chk("t4_addr", s_addr, 32'h0040_0200);
    step(1, 0);
    redir(32'h0040_0304, 1, 1); chk("t4_gated", s_wen | s_flush, 0);
    step(1, 0); chk("t4_addr2", s_addr, 32'h0040_0300);
    step(1, 0);
    step(1, 1); chk("t4_flush_full", s_flush, 1); chk("t4_off", s_off, 1);
                chk("t4_wdata", s_wdata, line_of(32'h0040_0300));
    // 5: wrap at top of address space
    redir(32'hFFFF_FFF4, 0, 0);
    step(1, 0); chk("t5_addr", s_addr, 32'hFFFF_FFF0);
    step(1, 0);
    step(1, 0); chk("t5_flush", s_flush, 1); chk("t5_off", s_off, 1);
    mem_delay_min = 3; mem_delay_max = 3;
    step(1, 0); chk("t5_wrap", s_addr, 32'h0000_0000);
    // 6: reset while waiting
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0); chk("t6_req_rst", s_req, 0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t6_req", s_req, 0); chk("t6_wen", s_wen | s_flush, 0); chk("t6_wdata", s_wdata, 0);
    chk("t6_off", s_off, 0); chk("t6_pend", s_pend, 1);
    mem_delay_min = 1; mem_delay_max = 1;
    step(1, 0); chk("t6_restart", s_addr, RST_PC);
    step(1, 0);
    step(1, 0); chk("t6_flush", s_flush, 1); chk("t6_off0", s_off, 0);
    // randomized traffic
    mem_delay_min = 1; mem_delay_max = 3;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
        2:       rpc = RST_PC + 32'($urandom_range(0, 255));
        default: rpc = 32'h0000_0000 + 32'($urandom_range(0, 63));
      endcase
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, rpc,
          $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
